// File: rtl/qr_pkg.sv
// ============================================================================
//  Module      : qr_pkg
//  Description : Shared types and sizes for the Q-column element datapath.
//                ELEM_W / VEC_N give the default element width and vector
//                length. gather_state_t encodes the receive-side gather FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qr_pkg;

    localparam int ELEM_W = 16;
    localparam int VEC_N  = 3;

    typedef logic [ELEM_W-1:0] elem_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } gather_state_t;

endpackage : qr_pkg

`default_nettype wire

// File: rtl/gather_idx_counter.sv
// ============================================================================
//  Module      : gather_idx_counter
//  Description : Element index counter that wraps at N. It is the team
//                counter with a restart input, which loads 1 because the
//                element that restarts a vector is always element 0.
//  Ports       : clk        - rising-edge clock
//                i_clr_n    - synchronous active-low clear (count <= 0)
//                i_en       - advance (or restart) this cycle
//                i_restart  - with i_en: load 1 instead of incrementing
//                o_count    - current index
//                o_tc       - terminal count (o_count == N-1)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gather_idx_counter
    import qr_pkg::*;
#(
    parameter int N  = VEC_N,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          i_clr_n,
    input  logic          i_en,
    input  logic          i_restart,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_restart) begin
                r_count <= CW'(1);
            end else if (o_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == CW'(N - 1));

endmodule : gather_idx_counter

`default_nettype wire

// File: rtl/q_i_dot_gather.sv
// ============================================================================
//  Module      : q_i_dot_gather
//  Description : Rebuilds an N-element vector from a serial stream of W-bit
//                elements (one per accepted cycle) and holds it stable until
//                the consumer acknowledges it. An in_first marker restarts
//                assembly, so a misaligned stream resynchronises.
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous active-low reset
//                in_valid   - in_data / in_first valid
//                in_first   - marks element 0 of a vector
//                in_data    - serial element
//                in_ready   - element can be accepted (COLLECT state)
//                q_vec      - assembled vector, element k at [k*W +: W]
//                vec_valid  - q_vec complete and stable
//                out_ack    - consumer has taken q_vec
//                seq_err    - one-cycle pulse per protocol violation
//                idx        - next element index expected
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_i_dot_gather
    import qr_pkg::*;
#(
    parameter int W  = ELEM_W,
    parameter int N  = VEC_N,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic           in_first,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    output logic [N*W-1:0] q_vec,
    output logic           vec_valid,
    input  logic           out_ack,
    output logic           seq_err,
    output logic [CW-1:0]  idx
);

    // A single-element vector would need to go FULL on the restart element,
    // which the restart path does not do.
    if (N < 2) begin : g_bad_n
        $error("q_i_dot_gather: N must be at least 2");
    end

    gather_state_t  r_state;
    gather_state_t  w_state_nxt;
    logic           r_seq_err;
    logic           w_seq_err_nxt;
    logic           w_accept;
    logic           w_write;
    logic           w_cnt_en;
    logic           w_restart;
    logic [CW-1:0]  w_idx;
    logic [CW-1:0]  w_wr_idx;
    logic           w_tc;
    logic [N*W-1:0] r_q_vec;

    gather_idx_counter #(
        .N  (N),
        .CW (CW)
    ) u_idx_cnt (
        .clk       (clk),
        .i_clr_n   (reset),
        .i_en      (w_cnt_en),
        .i_restart (w_restart),
        .o_count   (w_idx),
        .o_tc      (w_tc)
    );

    assign in_ready = (r_state == COLLECT);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= COLLECT;
            r_seq_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seq_err <= w_seq_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_write       = 1'b0;
        w_cnt_en      = 1'b0;
        w_restart     = 1'b0;
        w_wr_idx      = w_idx;
        w_seq_err_nxt = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_accept) begin
                    if (in_first) begin
                        // Restart always lands on element 0; a partial
                        // vector in progress is abandoned and flagged.
                        w_write       = 1'b1;
                        w_wr_idx      = '0;
                        w_cnt_en      = 1'b1;
                        w_restart     = 1'b1;
                        w_seq_err_nxt = (w_idx != '0);
                    end else if (w_idx == '0) begin
                        // Element 0 without its marker: drop it.
                        w_seq_err_nxt = 1'b1;
                    end else begin
                        w_write  = 1'b1;
                        w_cnt_en = 1'b1;
                        if (w_tc) begin
                            w_state_nxt = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (out_ack) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    for (genvar k = 0; k < N; k++) begin : g_elem
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_q_vec[k*W +: W] <= '0;
            end else if (w_write && (w_wr_idx == CW'(k))) begin
                r_q_vec[k*W +: W] <= in_data;
            end
        end
    end

    assign q_vec     = r_q_vec;
    assign vec_valid = (r_state == FULL);
    assign seq_err   = r_seq_err;
    assign idx       = w_idx;

endmodule : q_i_dot_gather

`default_nettype wire

// File: doc/q_i_dot_gather.md
Name: q_i_dot_gather

Overview:
- Receiver-side counterpart to the Q-column element serializer: accepts a stream of W-bit elements, one per cycle, and rebuilds the N-element vector (q1_l, q2_l, q3_l, ...) as parallel registers.
- Sits between the serial Q-element bus and the consumers (R-row dot-product and normalisation stages).
- Holds the assembled vector stable until the consumer acknowledges it.
- Uses a valid/ready handshake plus a first-element marker so a misaligned stream resynchronises.

Parameters:
- W, 16, element width in bits
- N, 3, elements per vector (N >= 2)
- CW, $clog2(N) (min 1), element index counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  in_data / in_first are valid this cycle
- in_first  in  1  marks element 0 of a vector
- in_data  in  W  serial element (q_i_dot stream)
- in_ready  out  1  block can accept an element this cycle
- q_vec  out  N*W  assembled vector; element k at bits [k*W +: W] (k=0 is q1_l)
- vec_valid  out  1  q_vec complete and stable
- out_ack  in  1  consumer has taken q_vec
- seq_err  out  1  one-cycle pulse on a protocol violation
- idx  out  CW  next element index expected (debug/visibility)

Behaviour:
- Reset (clk edge with reset==0): state=COLLECT, idx=0, q_vec=0, vec_valid=0, seq_err=0; in_ready=1 from the following cycle. Reset wins over every other input and aborts a partial vector.
- Accept condition: in_valid && in_ready.
- in_ready = (state == COLLECT); combinational from state only.
- States: COLLECT, FULL.
- COLLECT, accept with in_first=1:
  - in_data written to element 0; idx <= 1.
  - If idx != 0 at that moment, seq_err pulses (partial vector dropped, resync to 0).
- COLLECT, accept with in_first=0 and idx==0: element dropped, seq_err pulses, idx stays 0.
- COLLECT, accept with in_first=0 and 0<idx<N: in_data written to element idx; idx <= idx+1.
- Writing element N-1:
  - Next cycle: state=FULL, vec_valid=1, idx wraps to 0.
  - Latency: vec_valid rises 1 cycle after the last accepted element, i.e. N cycles minimum from the first element.
- FULL:
  - in_ready=0; q_vec frozen.
  - out_ack=1 → next cycle vec_valid=0, state=COLLECT.
  - No element is accepted in the ack cycle; back-to-back vectors therefore have a 1-cycle bubble.
- out_ack while in COLLECT: ignored, no error.
- Elements not yet written in the current vector keep their previous values; q_vec is only meaningful while vec_valid=1.
- seq_err is registered, high for exactly one cycle per violation, 0 otherwise.
- N=1 is not supported (enforced by a generate-time check).

Decomposition:
- Shared package (qr_pkg): ELEM_W=16, VEC_N=3, typedef elem_t (logic [ELEM_W-1:0]), typedef enum gather_state_t {COLLECT, FULL}.
- Reuse the team's counter as the index counter with a new wrap-at-N variant: gather_idx_counter (synchronous active-low clear, enable, terminal-count output).
- The rest is a flat module.

Test Plan:
- Reset then stream 0x0011(first), 0x0022, 0x0033 on consecutive cycles → vec_valid=1 the cycle after 0x0033; q_vec=0x0033_0022_0011; seq_err never asserted.
- While FULL, drive in_valid=1 with data 0xBEEF for 5 cycles, no out_ack → in_ready=0 throughout and q_vec unchanged; assert out_ack → vec_valid=0 next cycle, in_ready=1.
- Stream 0x1111(first), 0x2222, then 0xAAAA(first), 0xBBBB, 0xCCCC → seq_err pulses once on the 0xAAAA accept; final q_vec=0xCCCC_BBBB_AAAA.
- First element arrives without in_first (0x5555) → dropped, seq_err pulse, idx stays 0; a following correct 3-element vector assembles normally.
- Stream 0x0001(first), 0x0002, then reset low for one cycle → vec_valid=0, idx=0, q_vec=0; next vector 0x0007(first), 0x0008, 0x0009 gives q_vec=0x0009_0008_0007.
- Random in_valid gaps (~50% duty) over 3 vectors with out_ack on the 2nd cycle of each FULL → every vector matches the scoreboard and no element is lost or duplicated.
